// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared state encoding, board constants and seeding helpers for step_issuer
package game_pkg;

  localparam int TRACK_LEN   = 24;
  localparam int POS_W       = 5;
  localparam int MAX_PLAYERS = 4;
  localparam int STEP_W      = 3;

  typedef enum logic [1:0] {IDLE, PULSE, GAP, FIN} state_e;

  // Counts outside 2..4 fall back to a two-player game.
  function automatic logic [2:0] player_count(input logic [3:0] n);
    return (n >= 4'd2 && n <= 4'd4) ? n[2:0] : 3'd2;
  endfunction

  // Players start evenly spread around the lap; unused slots sit at 0.
  function automatic int start_offset(input int idx, input int n, input int track_len);
    return (idx < n) ? (idx * track_len) / n : 0;
  endfunction

  function automatic logic [1:0] next_turn(input logic [1:0] turn, input logic [2:0] n);
    return 2'(({1'b0, turn} + 3'd1) % n);
  endfunction

endpackage

// File: rtl/step_issuer_if.sv
// rtl/step_issuer_if.sv - turn request and player step signals between game logic and step_issuer
interface step_issuer_if #(
  parameter int MAX_PLAYERS = game_pkg::MAX_PLAYERS,
  parameter int POS_W       = game_pkg::POS_W,
  parameter int STEP_W      = game_pkg::STEP_W
);

  logic [3:0]                   N;
  logic                         start;
  logic                         hit;
  logic [STEP_W-1:0]            steps;
  logic [MAX_PLAYERS-1:0]       p_da;
  logic [1:0]                   turn;
  logic                         busy;
  logic                         done;
  logic [MAX_PLAYERS-1:0]       lap;
  logic [MAX_PLAYERS*POS_W-1:0] pos_flat;

  modport master (
    input  N, start, hit, steps,
    output p_da, turn, busy, done, lap, pos_flat
  );

  modport slave (
    output N, start, hit, steps,
    input  p_da, turn, busy, done, lap, pos_flat
  );

endinterface

// File: rtl/shadow_pos.sv
// rtl/shadow_pos.sv - one player's mod-LEN shadow track position with lap pulse
module shadow_pos #(
  parameter int W       = 5,
  parameter int LEN     = 24,
  parameter int RST_POS = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         seed_en,
  input  logic [W-1:0] seed,
  input  logic         step,
  output logic [W-1:0] pos,
  output logic         lap
);

  logic [W-1:0] pos_q;
  logic         at_end;

  assign at_end = (pos_q == W'(LEN - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pos_q <= W'(RST_POS);
    end else if (seed_en) begin
      pos_q <= seed;
    end else if (step) begin
      pos_q <= at_end ? '0 : pos_q + W'(1);
    end
  end

  assign pos = pos_q;
  // Lap is flagged during the pulse cycle whose increment wraps the position.
  assign lap = step && at_end;

endmodule

// File: rtl/step_issuer.sv
// rtl/step_issuer.sv - turn owner issuing one-cycle player step pulses; optional KEEP_TURN_ON_HIT_EN
module step_issuer #(
  parameter int MAX_PLAYERS = game_pkg::MAX_PLAYERS,
  parameter int POS_W       = game_pkg::POS_W,
  parameter int TRACK_LEN   = game_pkg::TRACK_LEN,
  parameter int STEP_W      = game_pkg::STEP_W
) (
  input logic           B,
  input logic           rst,
  step_issuer_if.master bus
);

  import game_pkg::state_e;
  import game_pkg::IDLE;
  import game_pkg::PULSE;
  import game_pkg::GAP;
  import game_pkg::FIN;
  import game_pkg::player_count;
  import game_pkg::start_offset;
  import game_pkg::next_turn;

`ifdef KEEP_TURN_ON_HIT_EN
  localparam bit KEEP_TURN = 1'b1;
`else
  localparam bit KEEP_TURN = 1'b0;
`endif

  state_e                 state, state_nx;
  logic [2:0]             n_q, n_nx;
  logic [1:0]             turn_q, turn_nx;
  logic [STEP_W-1:0]      rem_q, rem_nx;
  logic                   moved_q, moved_nx;
  logic [MAX_PLAYERS-1:0] p_da_q, p_da_nx;
  logic [2:0]             n_in;
  logic                   seed_en;

  assign n_in = player_count(bus.N);

  always_ff @(posedge B or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      n_q     <= 3'd2;
      turn_q  <= 2'd0;
      rem_q   <= '0;
      moved_q <= 1'b0;
      p_da_q  <= '0;
    end else begin
      state   <= state_nx;
      n_q     <= n_nx;
      turn_q  <= turn_nx;
      rem_q   <= rem_nx;
      moved_q <= moved_nx;
      p_da_q  <= p_da_nx;
    end
  end

  always_comb begin
    state_nx = state;
    n_nx     = n_q;
    turn_nx  = turn_q;
    rem_nx   = rem_q;
    moved_nx = moved_q;
    p_da_nx  = '0;
    seed_en  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          n_nx     = n_in;
          seed_en  = (n_in != n_q);
          moved_nx = bus.hit && (bus.steps != '0);
          rem_nx   = bus.steps;
          state_nx = (bus.hit && (bus.steps != '0)) ? PULSE : FIN;
        end
      end
      PULSE: begin
        rem_nx   = rem_q - 1'b1;
        state_nx = GAP;
      end
      GAP: begin
        state_nx = (rem_q != '0) ? PULSE : FIN;
      end
      FIN: begin
        turn_nx  = (KEEP_TURN && moved_q) ? turn_q : next_turn(turn_q, n_q);
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    // Pulse is registered so it lines up exactly with the PULSE state.
    if (state_nx == PULSE) begin
      p_da_nx = MAX_PLAYERS'(1) << turn_q;
    end
  end

  for (genvar i = 0; i < MAX_PLAYERS; i++) begin : g_pos
    shadow_pos #(
      .W       (POS_W),
      .LEN     (TRACK_LEN),
      .RST_POS (start_offset(i, 2, TRACK_LEN))
    ) u_pos (
      .clk     (B),
      .rst     (rst),
      .seed_en (seed_en),
      .seed    (POS_W'(start_offset(i, int'(n_nx), TRACK_LEN))),
      .step    (p_da_q[i]),
      .pos     (bus.pos_flat[i*POS_W +: POS_W]),
      .lap     (bus.lap[i])
    );
  end

  assign bus.p_da = p_da_q;
  assign bus.turn = turn_q;
  assign bus.busy = (state != IDLE);
  assign bus.done = (state == FIN);

endmodule
